// File: rtl/ren_bypass_s1_if.sv
// ---------------------------------------------------------------------------
// ren_bypass_s1_if
// Bundles the stage0 -> stage1 rename group, the stage1 -> dispatch group and
// the two handshakes. Signal names keep their direction suffix as seen from
// ren_bypass_s1.
//   slave  : view used by ren_bypass_s1 (consumes s0_*, ds_rdy_i; drives s1_*)
//   master : view used by the surrounding pipeline / testbench
// Ports carried:
//   s0_vld_i / s0_rdy_o            stage0 group handshake
//   s0_slot_vld_i, s0_rd_vld_i     per-slot valid and dest-valid masks
//   s0_psrc1_i/psrc2_i/pold_i      RAT mappings, slot k at [k*PREG_W +: PREG_W]
//   s0_pnew_i                      freelist-allocated destinations
//   s0_rs1/rs2/rd_sel_i            2-bit producer-slot select per slot
//   s1_vld_o / ds_rdy_i            dispatch handshake
//   s1_*_o                         registered, bypass-corrected group
//   s1_byp_cnt_o                   saturating substitution counter
// ---------------------------------------------------------------------------
interface ren_bypass_s1_if #(
  parameter int PREG_W = 7,
  parameter int NSLOT  = 4
);
  logic                    s0_vld_i;
  logic                    s0_rdy_o;
  logic [NSLOT-1:0]        s0_slot_vld_i;
  logic [NSLOT-1:0]        s0_rd_vld_i;
  logic [NSLOT*PREG_W-1:0] s0_psrc1_i;
  logic [NSLOT*PREG_W-1:0] s0_psrc2_i;
  logic [NSLOT*PREG_W-1:0] s0_pold_i;
  logic [NSLOT*PREG_W-1:0] s0_pnew_i;
  logic [2*NSLOT-1:0]      s0_rs1_sel_i;
  logic [2*NSLOT-1:0]      s0_rs2_sel_i;
  logic [2*NSLOT-1:0]      s0_rd_sel_i;
  logic                    s1_vld_o;
  logic                    ds_rdy_i;
  logic [NSLOT-1:0]        s1_slot_vld_o;
  logic [NSLOT-1:0]        s1_rd_vld_o;
  logic [NSLOT*PREG_W-1:0] s1_psrc1_o;
  logic [NSLOT*PREG_W-1:0] s1_psrc2_o;
  logic [NSLOT*PREG_W-1:0] s1_pdst_o;
  logic [NSLOT*PREG_W-1:0] s1_pold_o;
  logic [15:0]             s1_byp_cnt_o;

  modport slave (
    input  s0_vld_i, s0_slot_vld_i, s0_rd_vld_i,
    input  s0_psrc1_i, s0_psrc2_i, s0_pold_i, s0_pnew_i,
    input  s0_rs1_sel_i, s0_rs2_sel_i, s0_rd_sel_i,
    input  ds_rdy_i,
    output s0_rdy_o, s1_vld_o, s1_slot_vld_o, s1_rd_vld_o,
    output s1_psrc1_o, s1_psrc2_o, s1_pdst_o, s1_pold_o, s1_byp_cnt_o
  );

  modport master (
    output s0_vld_i, s0_slot_vld_i, s0_rd_vld_i,
    output s0_psrc1_i, s0_psrc2_i, s0_pold_i, s0_pnew_i,
    output s0_rs1_sel_i, s0_rs2_sel_i, s0_rd_sel_i,
    output ds_rdy_i,
    input  s0_rdy_o, s1_vld_o, s1_slot_vld_o, s1_rd_vld_o,
    input  s1_psrc1_o, s1_psrc2_o, s1_pdst_o, s1_pold_o, s1_byp_cnt_o
  );
endinterface

// File: rtl/ren_bypass_s1.sv
// ---------------------------------------------------------------------------
// ren_bypass_s1
// Rename stage1. Takes the RAT-read mappings of a 4-wide rename group and
// replaces any source / old-dest mapping whose select points at an earlier
// slot with that slot's freshly allocated destination. The corrected group is
// held in a single valid/ready pipeline register toward dispatch.
// Ports:
//   clk_i    core clock
//   rst_n_i  asynchronous active-low reset
//   flush_i  pipeline flush, dominates every other action
//   bus      ren_bypass_s1_if.slave (stage0 group in, dispatch group out)
// ---------------------------------------------------------------------------
module ren_bypass_s1 #(
  parameter int PREG_W = 7,
  parameter int NSLOT  = 4
) (
  input logic              clk_i,
  input logic              rst_n_i,
  input logic              flush_i,
  ren_bypass_s1_if.slave   bus
);

  localparam int W = NSLOT * PREG_W;

  // A select pointing at an earlier slot takes that slot's new pdst. A select
  // equal to or above its own slot keeps the RAT value, so slot0 can never
  // be overridden.
  function automatic logic [W-1:0] applySel(input logic [W-1:0]       rat,
                                            input logic [W-1:0]       pnew,
                                            input logic [2*NSLOT-1:0] sel);
    logic [W-1:0] res;
    res = rat;
    for (int k = 1; k < NSLOT; k++) begin
      if (int'(sel[2*k +: 2]) < k)
        res[k*PREG_W +: PREG_W] = pnew[int'(sel[2*k +: 2])*PREG_W +: PREG_W];
    end
    return res;
  endfunction

  // Number of overrides among the slots enabled in 'mask'.
  function automatic logic [3:0] countOvr(input logic [2*NSLOT-1:0] sel,
                                          input logic [NSLOT-1:0]   mask);
    logic [3:0] cnt;
    cnt = '0;
    for (int k = 1; k < NSLOT; k++) begin
      if (mask[k] && (int'(sel[2*k +: 2]) < k))
        cnt = cnt + 4'd1;
    end
    return cnt;
  endfunction

  logic             s1Vld_q, s1Vld_d;
  logic [NSLOT-1:0] slotVld_q, slotVld_d;
  logic [NSLOT-1:0] rdVld_q, rdVld_d;
  logic [W-1:0]     psrc1_q, psrc1_d;
  logic [W-1:0]     psrc2_q, psrc2_d;
  logic [W-1:0]     pdst_q, pdst_d;
  logic [W-1:0]     pold_q, pold_d;
  logic [15:0]      bypCnt_q, bypCnt_d;

  logic [W-1:0]     psrc1Byp, psrc2Byp, poldByp;
  logic [3:0]       ovrTotal;
  logic [16:0]      cntSum;
  logic             s0Rdy;
  logic             load;

  // Bypass network: corrected mappings for the incoming group and how many
  // substitutions it contributes. Old-dest overrides only count where the slot
  // actually writes a destination.
  always_comb begin
    psrc1Byp = applySel(bus.s0_psrc1_i, bus.s0_pnew_i, bus.s0_rs1_sel_i);
    psrc2Byp = applySel(bus.s0_psrc2_i, bus.s0_pnew_i, bus.s0_rs2_sel_i);
    poldByp  = applySel(bus.s0_pold_i,  bus.s0_pnew_i, bus.s0_rd_sel_i);
    ovrTotal = countOvr(bus.s0_rs1_sel_i, bus.s0_slot_vld_i)
             + countOvr(bus.s0_rs2_sel_i, bus.s0_slot_vld_i)
             + countOvr(bus.s0_rd_sel_i,  bus.s0_slot_vld_i & bus.s0_rd_vld_i);
  end

  // The register can take a new group when it is empty or being drained in
  // the same cycle; s0 valid does not feed back into ready.
  assign s0Rdy = !s1Vld_q | bus.ds_rdy_i;
  assign load  = bus.s0_vld_i & s0Rdy & !flush_i;

  // Next-state: flush empties the stage and drops the incoming group, a load
  // replaces the held group (also when it drains the same cycle), and a drain
  // without load only clears valid. Data registers hold otherwise, which keeps
  // the outputs stable under backpressure.
  always_comb begin
    s1Vld_d   = s1Vld_q;
    slotVld_d = slotVld_q;
    rdVld_d   = rdVld_q;
    psrc1_d   = psrc1_q;
    psrc2_d   = psrc2_q;
    pdst_d    = pdst_q;
    pold_d    = pold_q;
    bypCnt_d  = bypCnt_q;
    cntSum    = {1'b0, bypCnt_q} + 17'(ovrTotal);
    if (flush_i) begin
      s1Vld_d   = 1'b0;
      slotVld_d = '0;
      rdVld_d   = '0;
    end else if (load) begin
      s1Vld_d   = 1'b1;
      slotVld_d = bus.s0_slot_vld_i;
      rdVld_d   = bus.s0_rd_vld_i;
      psrc1_d   = psrc1Byp;
      psrc2_d   = psrc2Byp;
      pdst_d    = bus.s0_pnew_i;
      pold_d    = poldByp;
      bypCnt_d  = cntSum[16] ? 16'hFFFF : cntSum[15:0];
    end else if (s1Vld_q && bus.ds_rdy_i) begin
      s1Vld_d   = 1'b0;
    end
  end

  // Pipeline register toward dispatch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1Vld_q   <= 1'b0;
      slotVld_q <= '0;
      rdVld_q   <= '0;
      psrc1_q   <= '0;
      psrc2_q   <= '0;
      pdst_q    <= '0;
      pold_q    <= '0;
      bypCnt_q  <= '0;
    end else begin
      s1Vld_q   <= s1Vld_d;
      slotVld_q <= slotVld_d;
      rdVld_q   <= rdVld_d;
      psrc1_q   <= psrc1_d;
      psrc2_q   <= psrc2_d;
      pdst_q    <= pdst_d;
      pold_q    <= pold_d;
      bypCnt_q  <= bypCnt_d;
    end
  end

  assign bus.s0_rdy_o      = s0Rdy;
  assign bus.s1_vld_o      = s1Vld_q;
  assign bus.s1_slot_vld_o = slotVld_q;
  assign bus.s1_rd_vld_o   = rdVld_q;
  assign bus.s1_psrc1_o    = psrc1_q;
  assign bus.s1_psrc2_o    = psrc2_q;
  assign bus.s1_pdst_o     = pdst_q;
  assign bus.s1_pold_o     = pold_q;
  assign bus.s1_byp_cnt_o  = bypCnt_q;

endmodule
